// File: rtl/barrel_shifter_lr.sv
// barrel_shifter_lr: registered 16-bit left/right barrel shifter (1-cycle latency).
// Optional rotate support is compiled in with `define BARREL_ROTATE_EN.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   in_valid  - qualifies data_in / shift_by / right (/ rotate)
//   data_in   - operand, WIDTH bits
//   shift_by  - shift amount 0..31, unsigned
//   right     - 0 = shift toward MSB, 1 = shift toward LSB
//   rotate    - (BARREL_ROTATE_EN only) 1 = wrap bits instead of zero-fill
//   out_valid - registered copy of in_valid
//   data_out  - registered shift result, held while in_valid is low
module barrel_shifter_lr #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic [4:0]       shift_by,
    input  logic             right,
`ifdef BARREL_ROTATE_EN
    input  logic             rotate,
`endif
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out
);

    localparam int NSTG = 5;

    logic             w_rot;
    logic [WIDTH-1:0] w_l [NSTG+1];
    logic [WIDTH-1:0] w_r [NSTG+1];
    logic [WIDTH-1:0] w_res;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

`ifdef BARREL_ROTATE_EN
    assign w_rot = rotate;
`else
    assign w_rot = 1'b0;
`endif

    assign w_l[0] = data_in;
    assign w_r[0] = data_in;

    // Stage k moves the word by 2^k. In rotate mode the bits shifted out
    // are ORed back into the vacated end; the 16-position stage then
    // reduces to a pass-through, which gives the mod-16 behaviour.
    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int S = 1 << k;

        logic [WIDTH-1:0] w_lsh;
        logic [WIDTH-1:0] w_rsh;
        logic [WIDTH-1:0] w_lwrap;
        logic [WIDTH-1:0] w_rwrap;

        assign w_lsh   = w_l[k] << S;
        assign w_rsh   = w_r[k] >> S;
        assign w_lwrap = w_rot ? (w_l[k] >> (WIDTH - S)) : '0;
        assign w_rwrap = w_rot ? (w_r[k] << (WIDTH - S)) : '0;

        assign w_l[k+1] = shift_by[k] ? (w_lsh | w_lwrap) : w_l[k];
        assign w_r[k+1] = shift_by[k] ? (w_rsh | w_rwrap) : w_r[k];
    end

    // Per-bit 2:1 output select.
    for (genvar b = 0; b < WIDTH; b++) begin : g_sel
        assign w_res[b] = right ? w_r[NSTG][b] : w_l[NSTG][b];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_data <= w_res;
            end
        end
    end

    assign out_valid = r_valid;
    assign data_out  = r_data;

endmodule

// File: tb/tb_barrel_shifter_lr.sv
// tb_barrel_shifter_lr: directed self-checking bench for barrel_shifter_lr.
// Rotate vectors are included when BARREL_ROTATE_EN is defined.
module tb_barrel_shifter_lr;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] data_in;
    logic [4:0]  shift_by;
    logic        right;
    logic        rotate;
    logic        out_valid;
    logic [15:0] data_out;

    int vecs;
    int errs;

    barrel_shifter_lr #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .data_in  (data_in),
        .shift_by (shift_by),
        .right    (right),
`ifdef BARREL_ROTATE_EN
        .rotate   (rotate),
`endif
        .out_valid(out_valid),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one input set, take one edge, land 1 time unit past it.
    task automatic do_op(input logic [15:0] d, input logic [4:0] s,
                         input logic r, input logic rot, input logic v);
        data_in  = d;
        shift_by = s;
        right    = r;
        rotate   = rot;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        do_op(16'hFFFF, 5'd0, 1'b0, 1'b0, 1'b1);
        vecs++;
        if (data_out !== 16'h0000 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_init: got data=%h valid=%b want 0000/0",
                     data_out, out_valid);
        end
        rst = 1'b0;
        do_op(16'h5A5A, 5'd0, 1'b0, 1'b0, 1'b1);
        vecs++;
        if (data_out !== 16'h5A5A || out_valid !== 1'b1) begin
            errs++;
            $display("FAIL reset_load: got data=%h valid=%b want 5a5a/1",
                     data_out, out_valid);
        end
        rst = 1'b1;
        do_op(16'hFFFF, 5'd0, 1'b0, 1'b0, 1'b1);
        vecs++;
        if (data_out !== 16'h0000 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_prio: got data=%h valid=%b want 0000/0",
                     data_out, out_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_left();
        logic [15:0] d [6]   = '{16'hFFFF, 16'h0001, 16'h0001, 16'h0001,
                                 16'h00F0, 16'h0001};
        logic [4:0]  s [6]   = '{5'd15, 5'd1, 5'd2, 5'd8, 5'd6, 5'd5};
        logic [15:0] exp [6] = '{16'h8000, 16'h0002, 16'h0004, 16'h0100,
                                 16'h3C00, 16'h0020};
        for (int i = 0; i < 6; i++) begin
            do_op(d[i], s[i], 1'b0, 1'b0, 1'b1);
            vecs++;
            if (data_out !== exp[i] || out_valid !== 1'b1) begin
                errs++;
                $display("FAIL left_%0d: got data=%h valid=%b want %h/1",
                         i, data_out, out_valid, exp[i]);
            end
        end
    endtask

    task automatic test_right();
        logic [15:0] d [5]   = '{16'hFFFF, 16'h1234, 16'h8000, 16'h8000,
                                 16'hF00F};
        logic [4:0]  s [5]   = '{5'd15, 5'd4, 5'd1, 5'd8, 5'd3};
        logic [15:0] exp [5] = '{16'h0001, 16'h0123, 16'h4000, 16'h0080,
                                 16'h1E01};
        for (int i = 0; i < 5; i++) begin
            do_op(d[i], s[i], 1'b1, 1'b0, 1'b1);
            vecs++;
            if (data_out !== exp[i] || out_valid !== 1'b1) begin
                errs++;
                $display("FAIL right_%0d: got data=%h valid=%b want %h/1",
                         i, data_out, out_valid, exp[i]);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [15:0] d [6]   = '{16'hA5C3, 16'hA5C3, 16'hFFFF, 16'hFFFF,
                                 16'hFFFF, 16'hFFFF};
        logic [4:0]  s [6]   = '{5'd0, 5'd0, 5'd16, 5'd16, 5'd31, 5'd31};
        logic        r [6]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] exp [6] = '{16'hA5C3, 16'hA5C3, 16'h0000, 16'h0000,
                                 16'h0000, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            do_op(d[i], s[i], r[i], 1'b0, 1'b1);
            vecs++;
            if (data_out !== exp[i] || out_valid !== 1'b1) begin
                errs++;
                $display("FAIL bound_%0d: got data=%h valid=%b want %h/1",
                         i, data_out, out_valid, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d [3]   = '{16'h0001, 16'h8000, 16'h1234};
        logic [4:0]  s [3]   = '{5'd4, 5'd3, 5'd8};
        logic        r [3]   = '{1'b0, 1'b1, 1'b0};
        logic [15:0] exp [3] = '{16'h0010, 16'h1000, 16'h3400};
        for (int i = 0; i < 3; i++) begin
            do_op(d[i], s[i], r[i], 1'b0, 1'b1);
            vecs++;
            if (data_out !== exp[i] || out_valid !== 1'b1) begin
                errs++;
                $display("FAIL b2b_%0d: got data=%h valid=%b want %h/1",
                         i, data_out, out_valid, exp[i]);
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 2; i++) begin
            do_op(16'hBEEF, 5'd2, 1'b1, 1'b0, 1'b0);
            vecs++;
            if (data_out !== 16'h3400 || out_valid !== 1'b0) begin
                errs++;
                $display("FAIL hold_%0d: got data=%h valid=%b want 3400/0",
                         i, data_out, out_valid);
            end
        end
    endtask

`ifdef BARREL_ROTATE_EN
    task automatic test_rotate();
        logic [4:0]  s [5]   = '{5'd1, 5'd1, 5'd17, 5'd16, 5'd1};
        logic        r [5]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        rt [5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] exp [5] = '{16'h0003, 16'hC000, 16'h0003, 16'h8001,
                                 16'h0002};
        for (int i = 0; i < 5; i++) begin
            do_op(16'h8001, s[i], r[i], rt[i], 1'b1);
            vecs++;
            if (data_out !== exp[i] || out_valid !== 1'b1) begin
                errs++;
                $display("FAIL rot_%0d: got data=%h valid=%b want %h/1",
                         i, data_out, out_valid, exp[i]);
            end
        end
    endtask
`endif

    initial begin
        vecs     = 0;
        errs     = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;
        shift_by = '0;
        right    = 1'b0;
        rotate   = 1'b0;
        @(negedge clk);
        test_reset();
        test_left();
        test_right();
        test_boundaries();
        test_back_to_back();
        test_hold();
`ifdef BARREL_ROTATE_EN
        test_rotate();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
